regmap_core: RTL and testbench

Register-map endpoint on the Bus2Reg side of the AXI4-Lite slave: it consumes bus_req / bus_addr / bus_wr_data / bus_wr_biten, decodes six 32-bit registers, applies bit-enabled writes, and returns bus_ready plus held bus_rd_data. It carries the control, status, scratch, interrupt and version registers for one peripheral. It drives ctrl_o and irq_o toward the datapath.

---
 rtl/regmap_pkg.sv | 23 ++
 rtl/regmap_irq.sv | 36 +++
 rtl/regmap_core.sv | 152 +++++++++++++++
 tb/tb_regmap_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regmap_pkg.sv
// rtl/regmap_pkg.sv - register offsets, FSM state type and bit-enable write helper for regmap_core
package regmap_pkg;

  localparam logic [4:0] CTRL_OFS       = 5'h00;
  localparam logic [4:0] STATUS_OFS     = 5'h04;
  localparam logic [4:0] SCRATCH_OFS    = 5'h08;
  localparam logic [4:0] INT_STATUS_OFS = 5'h0C;
  localparam logic [4:0] INT_ENABLE_OFS = 5'h10;
  localparam logic [4:0] VERSION_OFS    = 5'h14;

  typedef enum logic [1:0] {
    RM_IDLE,
    RM_WAIT,
    RM_RESP
  } regmap_state_t;

  function automatic logic [31:0] apply_biten(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [31:0] biten);
    return (old & ~biten) | (wdata & biten);
  endfunction

endpackage

// File: rtl/regmap_irq.sv
// rtl/regmap_irq.sv - INT_STATUS (W1C, set wins) / INT_ENABLE registers and registered irq
module regmap_irq
  import regmap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hw_event,
  input  logic        clr_we,
  input  logic        en_we,
  input  logic [31:0] wdata,
  input  logic [31:0] biten,
  output logic [31:0] int_status,
  output logic [31:0] int_enable,
  output logic        irq
);

  logic [31:0] clr_mask;

  assign clr_mask = clr_we ? (wdata & biten) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_status <= '0;
      int_enable <= '0;
      irq        <= 1'b0;
    end else begin
      // OR-ing events after the clear makes a same-cycle set win over W1C
      int_status <= (int_status & ~clr_mask) | hw_event;
      if (en_we) begin
        int_enable <= apply_biten(int_enable, wdata, biten);
      end
      irq <= |(int_status & int_enable);
    end
  end

endmodule

// File: rtl/regmap_core.sv
// rtl/regmap_core.sv - Bus2Reg register-map endpoint; REGMAP_IRQ_EN enables the interrupt registers
module regmap_core
  import regmap_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] VERSION     = 32'h0001_0000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  bus_req,
  input  logic                  bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wr_data,
  input  logic [DATA_WIDTH-1:0] bus_wr_biten,
  input  logic                  bus_req_stall_wr,
  input  logic                  bus_req_stall_rd,
  output logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_rd_data,
  input  logic [31:0]           hw_status_i,
  input  logic [31:0]           hw_event_i,
  output logic [31:0]           ctrl_o,
  output logic                  irq_o
);

  regmap_state_t         state, state_next;
  logic [3:0]            wcnt, wcnt_next;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [31:0]           wdata_q, biten_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_win;
  logic [4:0]            ofs;
  logic                  wr_commit;
  logic [31:0]           scratch;
  logic [31:0]           rd_mux;
  logic                  unused_bits;

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    accept     = 1'b0;
    case (state)
      RM_IDLE: begin
        if (bus_req && !(bus_req_is_wr ? bus_req_stall_wr : bus_req_stall_rd)) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RM_RESP;
          end else begin
            state_next = RM_WAIT;
            wcnt_next  = 4'(WAIT_STATES - 1);
          end
        end
      end
      RM_WAIT: begin
        if (wcnt == 4'd0) state_next = RM_RESP;
        else              wcnt_next  = wcnt - 4'd1;
      end
      RM_RESP: state_next = RM_IDLE;
      default: state_next = RM_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= RM_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      biten_q <= '0;
    end else if (accept) begin
      addr_q  <= bus_addr;
      wr_q    <= bus_req_is_wr;
      wdata_q <= bus_wr_data;
      biten_q <= bus_wr_biten;
    end
  end

  // Unsigned wrap puts addresses below BASE_ADDR outside the window too
  assign offset    = addr_q - BASE_ADDR;
  assign in_win    = (offset[ADDR_WIDTH-1:5] == '0);
  assign ofs       = {offset[4:2], 2'b00};
  assign bus_ready = (state == RM_RESP);
  assign wr_commit = bus_ready && wr_q && in_win;

`ifdef REGMAP_IRQ_EN
  logic [31:0] int_status, int_enable;

  regmap_irq u_irq (
    .clk        (ACLK),
    .rst        (ARESET),
    .hw_event   (hw_event_i),
    .clr_we     (wr_commit && (ofs == INT_STATUS_OFS)),
    .en_we      (wr_commit && (ofs == INT_ENABLE_OFS)),
    .wdata      (wdata_q),
    .biten      (biten_q),
    .int_status (int_status),
    .int_enable (int_enable),
    .irq        (irq_o)
  );

  assign unused_bits = ^offset[1:0];
`else
  assign irq_o       = 1'b0;
  assign unused_bits = ^{hw_event_i, offset[1:0]};
`endif

  always_comb begin
    rd_mux = '0;
    if (in_win) begin
      case (ofs)
        CTRL_OFS:       rd_mux = ctrl_o;
        STATUS_OFS:     rd_mux = hw_status_i;
        SCRATCH_OFS:    rd_mux = scratch;
`ifdef REGMAP_IRQ_EN
        INT_STATUS_OFS: rd_mux = int_status;
        INT_ENABLE_OFS: rd_mux = int_enable;
`endif
        VERSION_OFS:    rd_mux = VERSION;
        default:        rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_o      <= '0;
      scratch     <= '0;
      bus_rd_data <= '0;
    end else if (bus_ready) begin
      if (wr_q) begin
        if (wr_commit && ofs == CTRL_OFS)    ctrl_o  <= apply_biten(ctrl_o, wdata_q, biten_q);
        if (wr_commit && ofs == SCRATCH_OFS) scratch <= apply_biten(scratch, wdata_q, biten_q);
      end else begin
        bus_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_regmap_core.sv
// tb/tb_regmap_core.sv - directed vector bench for regmap_core (WAIT_STATES 0 and 3 instances)
module tb_regmap_core;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req[2];
  logic        is_wr[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [31:0] biten[2];
  logic        stall_wr[2];
  logic        stall_rd[2];
  logic        ready[2];
  logic [31:0] rd_data[2];
  logic [31:0] hw_status[2];
  logic [31:0] hw_event[2];
  logic [31:0] ctrl[2];
  logic        irq[2];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regmap_core #(.WAIT_STATES(WS0)) u_dut0 (
    .ACLK(clk), .ARESET(rst), .bus_req(req[0]), .bus_req_is_wr(is_wr[0]),
    .bus_addr(addr[0]), .bus_wr_data(wdata[0]), .bus_wr_biten(biten[0]),
    .bus_req_stall_wr(stall_wr[0]), .bus_req_stall_rd(stall_rd[0]),
    .bus_ready(ready[0]), .bus_rd_data(rd_data[0]), .hw_status_i(hw_status[0]),
    .hw_event_i(hw_event[0]), .ctrl_o(ctrl[0]), .irq_o(irq[0])
  );

  regmap_core #(.WAIT_STATES(WS1)) u_dut3 (
    .ACLK(clk), .ARESET(rst), .bus_req(req[1]), .bus_req_is_wr(is_wr[1]),
    .bus_addr(addr[1]), .bus_wr_data(wdata[1]), .bus_wr_biten(biten[1]),
    .bus_req_stall_wr(stall_wr[1]), .bus_req_stall_rd(stall_rd[1]),
    .bus_ready(ready[1]), .bus_rd_data(rd_data[1]), .hw_status_i(hw_status[1]),
    .hw_event_i(hw_event[1]), .ctrl_o(ctrl[1]), .irq_o(irq[1])
  );

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] biten;
    logic [31:0] exp_rd;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, returns edges from request to bus_ready (-1 on timeout) and the held read data
  task automatic access(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] be,
                        output logic [31:0] rd, output int lat);
    req[k] = 1'b1; is_wr[k] = wr; addr[k] = a; wdata[k] = d; biten[k] = be;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready[k]) begin
        lat = i;
        break;
      end
    end
    req[k] = 1'b0;
    tick();
    rd = rd_data[k];
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 0; is_wr[k] = 0; addr[k] = 0; wdata[k] = 0; biten[k] = 0;
      stall_wr[k] = 0; stall_rd[k] = 0; hw_event[k] = 0;
    end
    hw_status[0] = 32'hDEAD_BEEF;
    hw_status[1] = 32'h1234_5678;

    vecs.push_back('{0, 1'b0, 32'h14, 32'h0,         32'h0,         32'h0001_0000, 32'h0000_0000});
    vecs.push_back('{0, 1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_FFFF});
    vecs.push_back('{0, 1'b0, 32'h00, 32'h0,         32'h0,         32'h0000_FFFF, 32'h0000_FFFF});
    vecs.push_back('{0, 1'b1, 32'h00, 32'h1234_0000, 32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h03, 32'h0,         32'h0,         32'h1234_FFFF, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h04, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b1, 32'h14, 32'h0,         32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h14, 32'h0,         32'h0,         32'h0001_0000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h40, 32'h0,         32'h0,         32'h0000_0000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b1, 32'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h18, 32'h0,         32'h0,         32'h0000_0000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b1, 32'h08, 32'hCAFE_F00D, 32'hFF00_FF00, 32'h0000_0000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h08, 32'h0,         32'h0,         32'hCA00_F000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b1, 32'h20, 32'h0,         32'hFFFF_FFFF, 32'hCA00_F000, 32'h1234_FFFF});
    vecs.push_back('{0, 1'b0, 32'h00, 32'h0,         32'h0,         32'h1234_FFFF, 32'h1234_FFFF});
    vecs.push_back('{1, 1'b1, 32'h08, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1, 1'b0, 32'h08, 32'h0,         32'h0,         32'hA5A5_A5A5, 32'h0000_0000});
    vecs.push_back('{1, 1'b1, 32'h04, 32'h0,         32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0000_0000});
    vecs.push_back('{1, 1'b0, 32'h04, 32'h0,         32'h0,         32'h1234_5678, 32'h0000_0000});

    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_ready%0d", k), 32'(ready[k]), 32'h0);
      check($sformatf("reset_rd_data%0d", k), rd_data[k], 32'h0);
      check($sformatf("reset_ctrl%0d", k), ctrl[k], 32'h0);
      check($sformatf("reset_irq%0d", k), 32'(irq[k]), 32'h0);
    end

    foreach (vecs[i]) begin
      access(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].biten, rd, lat);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(1 + (vecs[i].k == 0 ? WS0 : WS1)));
      check($sformatf("vec%0d_ctrl", i), ctrl[vecs[i].k], vecs[i].exp_ctrl);
    end

    // Read stall held for 5 cycles: no completion until released
    stall_rd[0] = 1'b1;
    req[0] = 1'b1; is_wr[0] = 1'b0; addr[0] = 32'h14;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_ready_c%0d", i), 32'(ready[0]), 32'h0);
    end
    stall_rd[0] = 1'b0;
    tick();
    check("stall_release_ready", 32'(ready[0]), 32'h1);
    req[0] = 1'b0;
    tick();
    check("stall_release_ready_pulse", 32'(ready[0]), 32'h0);
    check("stall_release_rd", rd_data[0], 32'h0001_0000);

`ifdef REGMAP_IRQ_EN
    hw_event[0] = 32'h1;
    tick();
    hw_event[0] = 32'h0;
    access(0, 1'b1, 32'h10, 32'h1, 32'hFFFF_FFFF, rd, lat);
    tick();
    check("irq_set", 32'(irq[0]), 32'h1);
    req[0] = 1'b1; is_wr[0] = 1'b1; addr[0] = 32'h0C; wdata[0] = 32'h1; biten[0] = 32'hFFFF_FFFF;
    tick();
    check("w1c_race_ready", 32'(ready[0]), 32'h1);
    hw_event[0] = 32'h1;
    req[0] = 1'b0;
    tick();
    hw_event[0] = 32'h0;
    access(0, 1'b0, 32'h0C, 32'h0, 32'h0, rd, lat);
    check("w1c_race_status", rd, 32'h1);
    check("w1c_race_irq", 32'(irq[0]), 32'h1);
    access(0, 1'b1, 32'h0C, 32'h1, 32'hFFFF_FFFF, rd, lat);
    check("w1c_irq_lag", 32'(irq[0]), 32'h1);
    tick();
    check("w1c_irq_clear", 32'(irq[0]), 32'h0);
    access(0, 1'b0, 32'h0C, 32'h0, 32'h0, rd, lat);
    check("w1c_status_clear", rd, 32'h0);
`else
    hw_event[0] = 32'h1;
    tick();
    hw_event[0] = 32'h0;
    access(0, 1'b1, 32'h10, 32'h1, 32'hFFFF_FFFF, rd, lat);
    tick();
    check("noirq_irq", 32'(irq[0]), 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, 32'h0, rd, lat);
    check("noirq_enable_rd", rd, 32'h0);
    access(0, 1'b0, 32'h0C, 32'h0, 32'h0, rd, lat);
    check("noirq_status_rd", rd, 32'h0);
`endif

    // Reset during WAIT aborts a CTRL write on the 3-wait-state instance
    req[1] = 1'b1; is_wr[1] = 1'b1; addr[1] = 32'h00; wdata[1] = 32'hFFFF_FFFF; biten[1] = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b1;
    req[1] = 1'b0;
    tick();
    check("abort_ready_in_reset", 32'(ready[1]), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("abort_ready_c%0d", i), 32'(ready[1]), 32'h0);
    end
    check("abort_ctrl", ctrl[1], 32'h0);
    check("abort_reset_ctrl0", ctrl[0], 32'h0);

    // Dropping bus_req during WAIT still completes the access
    req[1] = 1'b1; is_wr[1] = 1'b1; addr[1] = 32'h00; wdata[1] = 32'h0000_0055; biten[1] = 32'hFFFF_FFFF;
    tick();
    req[1] = 1'b0;
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (ready[1]) begin
        lat = i;
        break;
      end
    end
    check("drop_req_latency", 32'(lat), 32'(1 + WS1));
    tick();
    check("drop_req_ctrl", ctrl[1], 32'h0000_0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
